// File: rtl/rr_arbiter_hold_pkg.sv
// Shared types and helpers for the hold-capable round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Circular increment used to move the priority pointer past the last owner.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    if (v + 1 >= n) begin
      return 0;
    end
    return v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_hold_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_hold_if #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          timeout;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_hold_pick.sv
// Circular first-set search: lowest index at or after ptr, wrapping past N-1.
module rr_pick #(
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  int             sum;

  // Rotating a doubled copy puts position ptr at bit 0.
  assign dbl = {mask, mask} >> ptr;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = dbl[gi];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    off   = '0;
    sum   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = int'(ptr) + int'(off);
    if (sum >= N) begin
      sum = sum - N;
    end
    idx = IW'(sum);
  end

endmodule

// File: rtl/rr_arbiter_hold.sv
// Registered round-robin arbiter: owner keeps the grant while requesting,
// with an optional hold timeout that rotates ownership when others wait.
module rr_arbiter_hold
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int IW      = $clog2(N),
  localparam int CW      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input logic             clk,
  input logic             rst_n,
  rr_arbiter_hold_if.slave bus
);

  localparam logic [N-1:0]  ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_TOP = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_SAT = (MAX_HOLD == 0) ? CW'(1) : CW'(MAX_HOLD);

  state_t        state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [IW-1:0] grant_id_reg, grant_id_next;
  logic          timeout_reg, timeout_next;

  logic [N-1:0]  owner_mask;
  logic [N-1:0]  pre_mask;
  logic [IW-1:0] ptr_after;
  logic [IW-1:0] pick_ptr;
  logic          owner_active;
  logic          pick_found, pre_found;
  logic [IW-1:0] pick_idx, pre_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_owner
      assign owner_mask[gi] = (grant_id_reg == IW'(gi));
    end
  endgenerate

  assign ptr_after    = IW'(wrap_inc(int'(grant_id_reg), N));
  assign owner_active = bus.req[grant_id_reg];
  assign pre_mask     = bus.req & ~owner_mask;
  // From IDLE search from the stored pointer; while granting, from just past the owner.
  assign pick_ptr     = (state_reg == GRANT) ? ptr_after : ptr_reg;

  rr_pick #(.N(N)) u_pick_main (
    .mask  (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  rr_pick #(.N(N)) u_pick_preempt (
    .mask  (pre_mask),
    .ptr   (ptr_after),
    .found (pre_found),
    .idx   (pre_idx)
  );

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    timeout_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next    = ONE << pick_idx;
          grant_id_next = pick_idx;
          cnt_next      = CW'(1);
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (!owner_active) begin
          // Release wins over a coincident timeout.
          ptr_next = ptr_after;
          if (pick_found) begin
            grant_next    = ONE << pick_idx;
            grant_id_next = pick_idx;
            cnt_next      = CW'(1);
          end else begin
            grant_next = '0;
            state_next = IDLE;
          end
        end else if ((MAX_HOLD != 0) && (cnt_reg == CNT_TOP) && pre_found) begin
          ptr_next      = ptr_after;
          grant_next    = ONE << pre_idx;
          grant_id_next = pre_idx;
          cnt_next      = CW'(1);
          timeout_next  = 1'b1;
        end else if (cnt_reg < CNT_SAT) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_valid = |grant_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed and randomized checks of rr_arbiter_hold against a behavioural model.
module tb_rr_arbiter_hold;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_arbiter_hold_if #(.N(N)) bus ();

  rr_arbiter_hold #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    int p;
    logic [N-1:0] others;
    m_to = 1'b0;
    if (!m_busy) begin
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_busy  = 1'b1;
        m_owner = p;
        m_cnt   = 1;
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % N;
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_owner = p;
        m_cnt   = 1;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (MAXH != 0 && m_cnt == MAXH && others != '0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick(others, m_ptr);
        m_cnt   = 1;
        m_to    = 1'b1;
      end else if (m_cnt < MAXH) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    check({tag, "_grant"}, 32'(bus.grant), 32'(eg));
    check({tag, "_valid"}, 32'(bus.grant_valid), 32'(m_busy));
    check({tag, "_id"}, 32'(bus.grant_id), 32'(m_owner));
    check({tag, "_timeout"}, 32'(bus.timeout), 32'(m_to));
  endtask

  // Called at posedge+1; drives req, advances one edge, checks at posedge+1.
  task automatic step(input logic [N-1:0] r, input string tag);
    bus.req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_outputs(tag);
    $display("step %s req=%b grant=%b id=%0d timeout=%0b", tag, r, bus.grant, bus.grant_id, bus.timeout);
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    bus.req = r;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs("rst_low");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    #2;
    rst_n = 1'b1;
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    $display("async reset %s grant=%b", tag, bus.grant);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq [5];
    logic [N-1:0] r;
    rst_n = 1'b0;
    bus.req = '0;
    model_reset();
    #1;

    // 1. reset and asynchronous reset mid-grant
    do_reset(4'b1111);
    step(4'b1111, "t1_first");
    check("t1_grant_lit", 32'(bus.grant), 32'h1);
    step(4'b1111, "t1_hold");
    async_reset("t1_async");
    check("t1_async_lit", 32'(bus.grant), 32'h0);

    // 2. zero-bubble handoff
    do_reset(4'b0000);
    step(4'b0101, "t2_a");
    step(4'b0101, "t2_b");
    step(4'b0100, "t2_hand");
    check("t2_hand_lit", 32'(bus.grant), 32'h4);
    step(4'b0000, "t2_idle");
    check("t2_idle_lit", 32'(bus.grant), 32'h0);

    // 3. rotation
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    do_reset(4'b0000);
    step(4'b1111, "t3_start");
    check("t3_start_lit", 32'(bus.grant), 32'(seq[0]));
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, "t3_hold");
      step(4'b1111 & ~seq[i], "t3_drop");
      check("t3_rot_lit", 32'(bus.grant), 32'(seq[i+1]));
    end

    // 4. timeout
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(4'b0011, "t4_own0");
      check("t4_own0_lit", 32'(bus.grant), 32'h1);
    end
    step(4'b0011, "t4_pre1");
    check("t4_pre1_grant", 32'(bus.grant), 32'h2);
    check("t4_pre1_to", 32'(bus.timeout), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, "t4_own1");
      check("t4_own1_to", 32'(bus.timeout), 32'h0);
    end
    step(4'b0011, "t4_pre0");
    check("t4_pre0_grant", 32'(bus.grant), 32'h1);
    check("t4_pre0_to", 32'(bus.timeout), 32'h1);

    // 5. lone holder saturates without preemption
    do_reset(4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(4'b1000, "t5_lone");
      check("t5_lone_to", 32'(bus.timeout), 32'h0);
    end
    check("t5_cnt", 32'(dut.cnt_reg), 32'd4);

    // 6. release coincident with timeout
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++) step(4'b0011, "t6_own0");
    step(4'b0010, "t6_coll");
    check("t6_coll_grant", 32'(bus.grant), 32'h2);
    check("t6_coll_to", 32'(bus.timeout), 32'h0);

    // Randomized traffic, biased so owners tend to keep holding.
    do_reset(4'b0000);
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      if (m_busy && $urandom_range(0, 9) < 7) r[m_owner] = 1'b1;
      step(r, "rnd");
      check("rnd_onehot", 32'($onehot0(bus.grant)), 32'h1);
      if ($urandom_range(0, 59) == 0) async_reset("rnd_async");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_hold.md
Name: rr_arbiter_hold

Overview:
- Registered round-robin arbiter that shares one resource between N requesters.
- A grant is held while the owner keeps its request high.
- A hold-timeout counter forces rotation when other requesters are waiting, so no requester is starved.
- Sits in front of a shared resource alongside the fixed-priority arbiters, as the fair-share option.

Parameters:
- N, 4: number of request/grant lines (N >= 2).
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant while others wait. A value of 0 disables the timeout.
- IW, $clog2(N): width of grant_id (derived).
- CW, $clog2(MAX_HOLD+1): width of the hold counter (derived). Minimum width is 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  level requests; bit i high means requester i wants the resource or is still using it.
- grant  out  N  registered one-hot grant, or all zero.
- grant_valid  out  1  high when any grant bit is set.
- grant_id  out  IW  index of the current owner; holds its last value when grant_valid is low.
- timeout  out  1  one-cycle pulse on the edge where a preemption occurs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - ptr=0, cnt=0, state=IDLE.
  - Takes effect immediately, including in the middle of a grant.
- State register: IDLE or GRANT. ptr is the highest-priority index for the next pick.
- Pick function: the first set bit of the candidate mask searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (circular).
- IDLE:
  - If req != 0, pick among req. At that edge: grant=onehot(pick), grant_id=pick, cnt=1, state goes to GRANT.
  - Latency is 1 clock from req sampled high to grant high.
  - If req == 0, remain in IDLE.
- GRANT, release (req[grant_id]==0 at the edge):
  - ptr = grant_id+1, wrapping N-1 to 0.
  - Pick among req with that new ptr.
  - If there is a candidate, grant it at the same edge (zero-bubble handoff) with cnt=1.
  - Otherwise grant=0 and state goes to IDLE.
- GRANT, timeout (req[grant_id]==1, MAX_HOLD!=0, cnt==MAX_HOLD, and another req bit set):
  - Preempt: ptr = grant_id+1 (with wrap), grant the pick among req excluding the current owner.
  - Set cnt=1 and timeout=1 for exactly one cycle.
- GRANT, hold (otherwise): grant unchanged, cnt = min(cnt+1, MAX_HOLD), saturating.
- Simultaneous release and timeout: release takes precedence and timeout stays 0.
- Request changes of non-owners never disturb the current grant.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id always matches grant when grant_valid is high.
  - timeout is never high while grant_valid is low.

Decomposition:
- Package rr_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - a helper function for the wrap increment of ptr.
- One combinational sub-module, rr_pick (parameter N):
  - inputs: mask[N], ptr[IW];
  - outputs: found, idx[IW];
  - it is instantiated twice: once for the release/idle pick and once for the preempt pick (mask excludes the owner).

Test Plan (N=4, MAX_HOLD=4):
1. Reset: hold rst_n low with req=1111, then release and let one edge pass → grant=0001, grant_id=0. Assert rst_n low mid-cycle → grant=0000 at once, without waiting for a clock.
2. Zero-bubble handoff: req=0101, then drop bit 0 after 2 cycles → on the next edge grant=0100 with no zero cycle between the two grants. Then req=0000 → grant=0000, state IDLE.
3. Rotation: req=1111, each owner drops its bit for one cycle after 2 cycles of grant → grant sequence 0001, 0010, 0100, 1000, 0001.
4. Timeout: req=0011 held constant → grant=0001 for 4 cycles, then 0010 with timeout=1 for one cycle, then 0001 again after 4 more cycles.
5. Lone holder: req=1000 held for 10 cycles → grant stays 1000 throughout, timeout stays 0, cnt saturates at 4.
6. Release/timeout collision: req=0011; in the cycle where cnt==4, drop bit 0 → grant=0010 and timeout stays 0.
